// File: rtl/i2c_slave_regfile.sv
// I2C target with an internal register file, pointer auto-increment and repeated-START support.
// SCL/SDA are oversampled by clk; the bus is decoded into START/STOP/rise/fall events.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h67,
  parameter int         NUM_REGS    = 16,
  parameter bit         MSB_FIRST   = 1'b1,
  parameter int         SYNC_STAGES = 2,
  parameter int         REG_AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              DIR_EN,
  output logic [6:0]        ADRESS_OUT,
  output logic [7:0]        DATA_OUT,
  output logic              DATA_VALID,
  output logic              BUSY,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t            state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic              scl_s, sda_s, scl_d, sda_d;
  logic              start_ev, stop_ev, scl_rise, scl_fall;
  logic [7:0]        shreg, rx_byte, tx_shift;
  logic [3:0]        bit_cnt;
  logic [REG_AW-1:0] ptr, ptr_next;
  logic              rw, ack_rx, sda_o, load_bit, ptr_ok;
  logic [7:0]        regs [NUM_REGS];

  assign SDA = DIR_EN ? sda_o : 1'bz;

  // Synchronisers reset to the idle-bus level so leaving reset never looks like a bus event.
  always_ff @(posedge clk) begin
    if (RESET) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  // Bytes are always assembled in natural bit order, so R/W lands in bit 0 in both modes.
  assign rx_byte  = MSB_FIRST ? {shreg[6:0], sda_s} : {sda_s, shreg[7:1]};
  assign ptr_next = (int'(ptr) == NUM_REGS - 1) ? '0 : ptr + 1'b1;
  assign ptr_ok   = int'(shreg) < NUM_REGS;
  assign load_bit = MSB_FIRST ? regs[ptr][7] : regs[ptr][0];
  assign rd_data  = (int'(rd_addr) < NUM_REGS) ? regs[rd_addr] : 8'h00;

  // bit_cnt counts sampled bits; a fall with bit_cnt==8 closes the byte and opens the 9th slot.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_shift   <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      ack_rx     <= 1'b0;
      sda_o      <= 1'b1;
      DIR_EN     <= 1'b0;
      ADRESS_OUT <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      DATA_VALID <= 1'b0;
      if (start_ev) begin
        state   <= ADDR;
        bit_cnt <= '0;
        DIR_EN  <= 1'b0;
        sda_o   <= 1'b1;
      end else if (stop_ev) begin
        state   <= IDLE;
        bit_cnt <= '0;
        DIR_EN  <= 1'b0;
        sda_o   <= 1'b1;
        BUSY    <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, PTR, WDATA: begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (state == ADDR && bit_cnt == 4'd7) begin
              ADRESS_OUT <= rx_byte[7:1];
              rw         <= rx_byte[0];
            end
          end
          RDATA: bit_cnt <= bit_cnt + 4'd1;
          WDATA_ACK: begin
            regs[ptr]  <= shreg;
            DATA_OUT   <= shreg;
            DATA_VALID <= 1'b1;
            ptr        <= ptr_next;
          end
          RDATA_ACK: begin
            ack_rx <= ~sda_s;
            if (!sda_s) ptr <= ptr_next;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            if (ADRESS_OUT == SLAVE_ADDR) begin
              state  <= ADDR_ACK;
              DIR_EN <= 1'b1;
              sda_o  <= 1'b0;
              BUSY   <= 1'b1;
            end else begin
              state <= WAIT_STOP;
            end
          end
          ADDR_ACK: if (rw) begin
            state    <= RDATA;
            tx_shift <= regs[ptr];
            sda_o    <= load_bit;
          end else begin
            state  <= PTR;
            DIR_EN <= 1'b0;
            sda_o  <= 1'b1;
          end
          PTR: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            if (ptr_ok) begin
              ptr    <= shreg[REG_AW-1:0];
              state  <= PTR_ACK;
              DIR_EN <= 1'b1;
              sda_o  <= 1'b0;
            end else begin
              state <= WAIT_STOP;
            end
          end
          PTR_ACK, WDATA_ACK: begin
            state  <= WDATA;
            DIR_EN <= 1'b0;
            sda_o  <= 1'b1;
          end
          WDATA: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            state   <= WDATA_ACK;
            DIR_EN  <= 1'b1;
            sda_o   <= 1'b0;
          end
          RDATA: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            state   <= RDATA_ACK;
            DIR_EN  <= 1'b0;
            sda_o   <= 1'b1;
          end else begin
            tx_shift <= MSB_FIRST ? {tx_shift[6:0], 1'b0} : {1'b0, tx_shift[7:1]};
            sda_o    <= MSB_FIRST ? tx_shift[6] : tx_shift[1];
          end
          RDATA_ACK: if (ack_rx) begin
            state    <= RDATA;
            DIR_EN   <= 1'b1;
            tx_shift <= regs[ptr];
            sda_o    <= load_bit;
          end else begin
            state <= WAIT_STOP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
